// File: rtl/mem_pkg.sv
// Shared types and default geometry for the CPU memory responder.
package mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    BOOT_LO = 2'd0,
    BOOT_HI = 2'd1,
    RUN     = 2'd2
  } boot_state_e;
endpackage

// File: rtl/cpu_memory_responder_if.sv
// CPU bus plus program-load link, seen from the CPU/board side (master) and the memory (slave).
interface cpu_memory_responder_if
  import mem_pkg::*;
();
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              mem_load;
  logic [DATA_W-1:0] rdata;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              ld_ready;
  logic              cpu_hold;
  logic              boot_done;

  modport master (
    output addr, wdata, mem_load, ld_valid, ld_byte, ld_last,
    input  rdata, ld_ready, cpu_hold, boot_done
  );
  modport slave (
    input  addr, wdata, mem_load, ld_valid, ld_byte, ld_last,
    output rdata, ld_ready, cpu_hold, boot_done
  );
endinterface

// File: rtl/sram_sp.sv
// Single-port RAM: synchronous write, registered write-first read, read port forced to 0 when disabled.
module sram_sp #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array is deliberately unreset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_q <= '0;
    else if (!en_i) rdata_q <= '0;
    else if (we_i)  rdata_q <= wdata_i;
    else            rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu_memory_responder.sv
// Memory responder: boot loader assembles byte pairs into words from address 0, then hands the RAM to the CPU.
module cpu_memory_responder
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cpu_memory_responder_if.slave bus
);
  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        lo_q, lo_d;
  logic              ld_ready_q, cpu_hold_q, boot_done_q;

  logic              run, acc, boot_wr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  assign run     = (state_q == RUN);
  assign acc     = bus.ld_valid & ld_ready_q;
  assign boot_wr = acc & (state_q == BOOT_HI);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lo_d    = lo_q;
    case (state_q)
      BOOT_LO: if (acc) begin
        lo_d    = bus.ld_byte;
        state_d = BOOT_HI;
      end
      BOOT_HI: if (acc) begin
        // Last slot ends boot on its own so the pointer never wraps.
        if (bus.ld_last || ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = BOOT_LO;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = BOOT_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT_LO;
      ptr_q       <= '0;
      lo_q        <= '0;
      ld_ready_q  <= 1'b1;
      cpu_hold_q  <= 1'b1;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lo_q        <= lo_d;
      ld_ready_q  <= (state_d != RUN);
      cpu_hold_q  <= (state_d != RUN);
      boot_done_q <= (state_d == RUN);
    end
  end

  // Loader owns the port during boot; CPU bus is ignored until RUN.
  assign ram_we    = run ? bus.mem_load : boot_wr;
  assign ram_addr  = run ? bus.addr     : ptr_q;
  assign ram_wdata = run ? bus.wdata    : {bus.ld_byte, lo_q};

  sram_sp #(
    .AW   (ADDR_W),
    .DW   (DATA_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .en_i   (run),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(bus.rdata)
  );

  assign bus.ld_ready  = ld_ready_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.boot_done = boot_done_q;
endmodule

// File: tb/tb_cpu_memory_responder.sv
// Directed + randomized bench for cpu_memory_responder against a word-array reference model.
module tb_cpu_memory_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_memory_responder_if bus();
  cpu_memory_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: memory image, which words are defined, and boot progress.
  logic [15:0] ref_mem [4096];
  bit          known   [4096];
  bit          m_run;
  bit          m_have_lo;
  logic [7:0]  m_lo;
  int          m_ptr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".ld_ready"},  16'(bus.ld_ready),  16'(!m_run));
    chk({tag, ".cpu_hold"},  16'(bus.cpu_hold),  16'(!m_run));
    chk({tag, ".boot_done"}, 16'(bus.boot_done), 16'(m_run));
  endtask

  task automatic do_reset(input string tag);
    bus.ld_valid = 1'b0; bus.ld_byte = '0; bus.ld_last = 1'b0;
    bus.mem_load = 1'b0; bus.addr = '0;   bus.wdata = '0;
    rst = 1'b1;
    m_run = 1'b0; m_have_lo = 1'b0; m_ptr = 0;
    #2;
    chk_flags(tag);
    chk({tag, ".rdata"}, bus.rdata, 16'h0000);
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit booting;
    booting = !m_run;
    bus.ld_valid = 1'b1; bus.ld_byte = b; bus.ld_last = last;
    if (booting) begin
      if (!m_have_lo) begin
        m_lo = b; m_have_lo = 1'b1;
      end else begin
        ref_mem[m_ptr] = {b, m_lo};
        known[m_ptr]   = 1'b1;
        m_have_lo      = 1'b0;
        if (last || m_ptr == 4095) m_run = 1'b1;
        else m_ptr++;
      end
    end
    tick;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    if (booting) begin
      chk_flags("boot");
      chk("boot.rdata", bus.rdata, 16'h0000);
    end
  endtask

  task automatic cpu_op(input logic [11:0] a, input logic [15:0] d, input bit we);
    logic [15:0] exp;
    bit          kn;
    bus.addr = a; bus.wdata = d; bus.mem_load = we;
    kn  = we || known[a];
    exp = we ? d : ref_mem[a];
    if (we) begin ref_mem[a] = d; known[a] = 1'b1; end
    tick;
    bus.mem_load = 1'b0;
    if (kn) chk($sformatf("rd@%h", a), bus.rdata, exp);
  endtask

  initial begin
    // Phase A: random 3-word image, then random CPU traffic and write-first check.
    do_reset("rstA");
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 2; b++)
        send_byte(8'($urandom), (w == 2 && b == 1));
    chk_flags("runA");
    for (int i = 0; i < 3; i++) cpu_op(12'(i), 16'h0, 1'b0);
    cpu_op(12'h005, 16'hBEEF, 1'b1);
    cpu_op(12'h000, 16'h0, 1'b0);
    cpu_op(12'h005, 16'h0, 1'b0);
    for (int i = 0; i < 40; i++)
      cpu_op(12'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));

    // Phase B: spec image with CPU writes attempted during boot.
    do_reset("rstB");
    bus.mem_load = 1'b1; bus.addr = 12'h002; bus.wdata = 16'hFFFF;
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'hAB, 1'b1);
    bus.mem_load = 1'b0;
    chk_flags("runB");
    cpu_op(12'h001, 16'h0, 1'b0);
    cpu_op(12'h000, 16'h0, 1'b0);
    cpu_op(12'h002, 16'h0, 1'b0);
    chk("B.w0", ref_mem[0], 16'h1234);
    chk("B.w1", ref_mem[1], 16'hABCD);

    // Phase C: reset after the lo byte of word 3, then a 1-word reload.
    do_reset("rstC");
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
    do_reset("midboot");
    for (int i = 0; i < 3; i++) tick;
    chk_flags("idle");
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    chk_flags("runC");
    for (int i = 0; i < 4; i++) cpu_op(12'(i), 16'h0, 1'b0);

    // Phase D: full 4096-word image with no ld_last, plus trailing bytes.
    do_reset("rstD");
    for (int i = 0; i < 8196; i++) send_byte(8'($urandom), 1'b0);
    chk_flags("runD");
    chk("D.ptr", 16'(m_ptr), 16'h0FFF);
    cpu_op(12'hFFF, 16'h0, 1'b0);
    cpu_op(12'h000, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) cpu_op(12'($urandom), 16'h0, 1'b0);

    // Phase E: reset while running holds the CPU again.
    do_reset("rstE");
    chk_flags("bootE");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
